// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Control bundle driven onto the pipeline-register control pins.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic exmem_flush;
    logic memwb_bubble;
  } ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{idex_hold: 1'b1, exmem_hold: 1'b1, memwb_bubble: 1'b1,
                                    default: 1'b0};
  // Every register loads NOP controls while reset is held.
  localparam ctrl_t CTRL_RESET  = '{ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1,
                                    memwb_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  output logic       hazard
);

  assign hazard = idex_mem_read && (idex_rd != REG_X0) &&
                  ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer: load-use stalls, branch squashes, data-memory waits with timeout.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, nxt_state;
  logic [WAIT_W-1:0] wait_cnt, nxt_wait, wait_inc;
  logic              hazard, squash;
  ctrl_t             ctrl;

  load_use_detect u_load_use (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs2   (id_uses_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .hazard        (hazard)
  );

  assign wait_inc = wait_cnt + WAIT_W'(1);

  always_comb begin
    ctrl      = CTRL_RUN;
    nxt_state = state;
    nxt_wait  = wait_cnt;
    squash    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          ctrl      = CTRL_FREEZE;
          nxt_state = ST_MEM_WAIT;
          nxt_wait  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl     = CTRL_FREEZE;
          nxt_wait = wait_inc;
          if (wait_inc == WAIT_W'(MEM_TIMEOUT)) nxt_state = ST_ERROR;
        end else begin
          nxt_state = ST_RUN;
          nxt_wait  = '0;
        end
      end
      default: ctrl = CTRL_FREEZE;
    endcase
    // Release cycles fall through to the same squash/load-use rules as RUN,
    // acting on whatever the held EX/MEM and ID/EX registers contain.
    if (ctrl == CTRL_RUN) begin
      if (exmem_br_taken) begin
        squash           = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_bubble = 1'b1;
        ctrl.exmem_flush = 1'b1;
      end else if (hazard) begin
        ctrl.pc_write    = 1'b0;
        ctrl.ifid_write  = 1'b0;
        ctrl.idex_bubble = 1'b1;
      end
    end
    if (!rst_n) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= nxt_state;
      wait_cnt <= nxt_wait;
      if (nxt_state == ST_ERROR) mem_timeout <= 1'b1;
      if (!ctrl.pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (squash && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_hold    = ctrl.idex_hold;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_hold   = ctrl.exmem_hold;
  assign exmem_flush  = ctrl.exmem_flush;
  assign memwb_bubble = ctrl.memwb_bubble;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO   = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, idex_rd;
  logic             id_uses_rs2, idex_mem_read, exmem_br_taken, dmem_req, dmem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble;
  logic             exmem_hold, exmem_flush, memwb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .exmem_br_taken(exmem_br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: "are we waiting on memory", how long, and has it died.
  bit     m_waiting, m_dead, m_tmo;
  int     m_waited;
  longint m_stall, m_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
            exmem_hold, exmem_flush, memwb_bubble};
  endfunction

  task automatic model_clear();
    m_waiting = 0; m_dead = 0; m_tmo = 0; m_waited = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic set_in(input int rs1, input int rs2, input bit u2, input bit mr,
                        input int rd, input bit br, input bit req, input bit rdy);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs2 = u2; idex_mem_read = mr;
    idex_rd = 5'(rd); exmem_br_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    bit frozen, squash, stall, pcw;
    logic [7:0] exp;
    #1;
    if (!rst_n) model_clear();
    frozen = m_dead || (m_waiting ? !dmem_ready : (dmem_req && !dmem_ready));
    squash = !frozen && exmem_br_taken;
    stall  = !frozen && !squash && idex_mem_read && idex_rd != 0 &&
             (idex_rd == id_rs1 || (id_uses_rs2 && idex_rd == id_rs2));
    pcw    = !frozen && !stall;
    if (!rst_n)      exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    else if (frozen) exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    else             exp = {pcw, pcw, squash, 1'b0, squash | stall, 1'b0, squash, 1'b0};
    check("ctrl", 64'(obs_ctrl()), 64'(exp));
    check("mem_timeout", 64'(mem_timeout), 64'(m_tmo));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    @(posedge clk);
    if (rst_n) begin
      if (!pcw && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (squash && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (!m_dead) begin
        if (frozen) begin
          m_waited  = m_waiting ? m_waited + 1 : 1;
          m_waiting = 1;
          if (m_waited == TMO) begin m_dead = 1; m_tmo = 1; end
        end else begin
          m_waiting = 0; m_waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_ctrl"}, 64'(obs_ctrl()), 64'h2B);
    check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    check({tag, "_flush"}, 64'(flush_cnt), 64'd0);
    check({tag, "_tmo"}, 64'(mem_timeout), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // 1: load x5 in ID/EX, ID reads x5 -> one stall cycle
    set_in(5, 0, 0, 1, 5, 0, 0, 1); cycle();
    idle(); cycle();
    check("t1_stall_cnt", 64'(stall_cnt), 64'd1);

    // 2: load to x0, and rd matching an unused rs2 -> no stall
    set_in(0, 0, 1, 1, 0, 0, 0, 1); #1 check("t2_x0_pcw", 64'(pc_write), 64'd1); cycle();
    set_in(3, 7, 0, 1, 7, 0, 0, 1); #1 check("t2_rs2_pcw", 64'(pc_write), 64'd1); cycle();

    // 3: branch squash wins over load-use
    do_reset();
    set_in(9, 0, 0, 1, 9, 1, 0, 1); cycle();
    idle(); cycle();
    check("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    check("t3_stall_cnt", 64'(stall_cnt), 64'd0);

    // 4: three wait cycles then release; pending branch acts on release
    do_reset();
    for (int i = 0; i < 3; i++) begin set_in(0, 0, 0, 0, 0, 1, 1, 0); cycle(); end
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    #1 check("t4_release_pcw", 64'(pc_write), 64'd1);
    cycle();
    idle(); cycle();
    check("t4_stall_cnt", 64'(stall_cnt), 64'd3);
    check("t4_flush_cnt", 64'(flush_cnt), 64'd1);

    // 5: sixteen wait cycles -> timeout, permanent freeze, reset clears
    do_reset();
    for (int i = 0; i < TMO; i++) begin set_in(0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    check("t5_timeout", 64'(mem_timeout), 64'd1);
    for (int i = 0; i < 3; i++) begin idle(); cycle(); end
    check("t5_frozen_pcw", 64'(pc_write), 64'd0);
    check("t5_stall_cnt", 64'(stall_cnt), 64'(TMO + 3));
    async_reset_check("t5_rst");
    cycle();

    // 6: async reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) begin set_in(0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    async_reset_check("t6_rst");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle();
    check("t6_run_pcw", 64'(pc_write), 64'd1);

    // Randomized traffic with small register indices so collisions are frequent
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 0) do_reset();
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) < 2, $urandom_range(0, 3) != 0);
      if ((n / 300) % 4 == 3) dmem_ready = $urandom_range(0, 15) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
